// File: rtl/hamming_rx_deframer_pkg.sv
// Shared definitions for the Hamming(7,4) receive path: codeword geometry,
// bit positions used by both the deframer and the downstream decoder, and FSM states.
package hamming_rx_deframer_pkg;

    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned IDX_W  = 3;

    // Bit positions inside the 7-bit codeword; cw[0] is the first bit on the line.
    localparam int unsigned D3_POS = 6;
    localparam int unsigned D2_POS = 5;
    localparam int unsigned D1_POS = 4;
    localparam int unsigned P0_POS = 3;
    localparam int unsigned D0_POS = 2;
    localparam int unsigned P1_POS = 1;
    localparam int unsigned P2_POS = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/hamming_rx_deframer_bit_sync.sv
// Multi-flop synchroniser for an asynchronous serial line; resets to the idle (high) level.
module hamming_rx_deframer_bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hamming_rx_deframer.sv
// UART-style deframer: recovers one 7-bit Hamming codeword per frame and qualifies it
// for the decoder; frames with a bad stop bit are flagged and never forwarded.
module hamming_rx_deframer
    import hamming_rx_deframer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_in,
    output logic [CW_W-1:0] code_out,
    output logic            code_valid,
    output logic            code_en,
    output logic            frame_err,
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CW_W - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 1024) begin : g_bad_cpb
        $error("CLKS_PER_BIT out of range 4..1024");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..3");
    end

    logic             rxs;
    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [CW_W-1:0]  shift;

    hamming_rx_deframer_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_bit_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rxs)
    );

    // Pulses default low; the FSM returns to idle on the same edge that raises them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            code_en    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!rxs) begin
                        state <= StStart;
                        cnt   <= '0;
                    end
                end
                StStart: begin
                    if (cnt == HALF_LAST) begin
                        if (rxs) begin
                            state <= StIdle;
                        end else begin
                            state <= StData;
                            cnt   <= '0;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rxs;
                        if (idx == IDX_LAST) begin
                            state <= StStop;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= StIdle;
                        if (rxs) begin
                            code_out   <= shift;
                            code_valid <= 1'b1;
                            code_en    <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            code_en   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_hamming_rx_deframer.sv
// Directed bench for hamming_rx_deframer with a frame-level reference model and a
// per-cycle compare of the CLKS_PER_BIT=8 instance; a second instance covers odd CLKS_PER_BIT.
module tb_hamming_rx_deframer;

    localparam int CPB  = 8;
    localparam int CPB5 = 5;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx8, rx5;
    logic [6:0] code_out8, code_out5;
    logic       code_valid8, code_en8, frame_err8, busy8;
    logic       code_valid5, code_en5, frame_err5, busy5;

    hamming_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx8), .code_out(code_out8),
        .code_valid(code_valid8), .code_en(code_en8), .frame_err(frame_err8), .busy(busy8)
    );

    hamming_rx_deframer #(.CLKS_PER_BIT(CPB5), .SYNC_STAGES(SYNC)) dut5 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx5), .code_out(code_out5),
        .code_valid(code_valid5), .code_en(code_en5), .frame_err(frame_err5), .busy(busy5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output event per frame: the cycle its pulse must be visible and its kind.
    typedef struct {
        int         at;
        bit         good;
        logic [6:0] cw;
    } ev_t;

    ev_t        evq[$];
    logic [6:0] m_code = '0;
    bit         m_en   = 1'b0;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_valid = 0, n_err = 0, n_err5 = 0;
    int         valid_cycles[$];
    int         last_stop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] cw;
        cw[6] = n[3];
        cw[5] = n[2];
        cw[4] = n[1];
        cw[2] = n[0];
        cw[3] = n[3] ^ n[2] ^ n[1];
        cw[1] = n[3] ^ n[2] ^ n[0];
        cw[0] = n[3] ^ n[1] ^ n[0];
        return cw;
    endfunction

    bit         pulse, pgood;
    logic [6:0] pcw;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            pulse = (evq.size() > 0) && (evq[0].at == cyc);
            pgood = 1'b0;
            pcw   = '0;
            if (pulse) begin
                pgood = evq[0].good;
                pcw   = evq[0].cw;
                void'(evq.pop_front());
                if (pgood) begin
                    m_code = pcw;
                    m_en   = 1'b1;
                end else begin
                    m_en = 1'b0;
                end
            end
            check("code_valid", code_valid8, pulse && pgood);
            check("frame_err", frame_err8, pulse && !pgood);
            check("code_out", code_out8, m_code);
            check("code_en", code_en8, m_en);
            if (code_valid8) begin
                n_valid++;
                valid_cycles.push_back(cyc);
            end
            if (frame_err8) n_err++;
            if (frame_err5) n_err5++;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller must be aligned (just after a rising edge); leaves the bench aligned.
    task automatic send(input bit sel5, input logic [6:0] cw, input bit stop);
        int         cpb;
        logic [8:0] bits;
        cpb  = sel5 ? CPB5 : CPB;
        bits = {stop, cw, 1'b0};
        for (int i = 0; i < 9; i++) begin
            if (sel5) rx5 = bits[i];
            else      rx8 = bits[i];
            if (i == 8) begin
                last_stop = cyc;
                if (!sel5) evq.push_back('{cyc + SYNC + CPB / 2 + 1, stop, cw});
            end
            repeat (cpb) @(posedge clk);
            #1;
        end
        if (sel5) rx5 = 1'b1;
        else      rx8 = 1'b1;
    endtask

    task automatic model_reset();
        evq.delete();
        m_code = '0;
        m_en   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int nv0, ne0, vc0, busy_cnt, t5;

    initial begin
        rst_n = 1'b0;
        rx8   = 1'b1;
        rx5   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_code_out", code_out8, 7'h00);
        check("rst_code_valid", code_valid8, 1'b0);
        check("rst_code_en", code_en8, 1'b0);
        check("rst_frame_err", frame_err8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_busy5", busy5, 1'b0);
        align();
        rst_n = 1'b1;
        idle(4);

        // 1: reset in the middle of a frame's data bits
        rx8 = 1'b0;
        idle(CPB + 2);
        rx8 = 1'b1;
        idle(CPB);
        @(negedge clk);
        check("midframe_busy", busy8, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", busy8, 1'b0);
        check("midrst_code_out", code_out8, 7'h00);
        align();
        rst_n = 1'b1;
        idle(5);
        check("post_rst_busy", busy8, 1'b0);
        check("post_rst_en", code_en8, 1'b0);
        check("post_rst_valid", code_valid8, 1'b0);
        send(1'b0, enc(4'b1011), 1'b1);
        idle(10);
        check("t1_code_out", code_out8, 7'h55);
        check("t1_n_valid", n_valid, 1);

        // 2: single good frame, explicit latency from the stop-bit edge
        nv0 = n_valid;
        send(1'b0, 7'h55, 1'b1);
        idle(10);
        check("t2_pulses", n_valid - nv0, 1);
        check("t2_no_err", n_err, 0);
        check("t2_code_out", code_out8, 7'h55);
        check("t2_code_en", code_en8, 1'b1);
        check("t2_latency", valid_cycles[valid_cycles.size() - 1] - last_stop, SYNC + CPB / 2 + 1);

        // 3: back-to-back frames with no idle gap
        vc0 = valid_cycles.size();
        send(1'b0, 7'h55, 1'b1);
        send(1'b0, enc(4'b0100), 1'b1);
        idle(10);
        check("t3_pulses", valid_cycles.size() - vc0, 2);
        if (valid_cycles.size() - vc0 == 2)
            check("t3_spacing", valid_cycles[vc0 + 1] - valid_cycles[vc0], 72);
        check("t3_code_out", code_out8, 7'h2A);

        // 4: bad stop bit
        nv0 = n_valid;
        send(1'b0, 7'h7F, 1'b0);
        idle(20);
        check("t4_err_pulses", n_err, 1);
        check("t4_no_valid", n_valid - nv0, 0);
        check("t4_code_out_held", code_out8, 7'h2A);
        check("t4_code_en", code_en8, 1'b0);

        // 5: 3-cycle low glitch on an idle line
        nv0 = n_valid;
        ne0 = n_err;
        busy_cnt = 0;
        rx8 = 1'b0;
        idle(3);
        rx8 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
        end
        align();
        check("t5_busy_seen", busy_cnt > 0, 1'b1);
        check("t5_busy_le6", busy_cnt <= 6, 1'b1);
        check("t5_no_valid", n_valid - nv0, 0);
        check("t5_no_err", n_err - ne0, 0);
        check("t5_code_out", code_out8, 7'h2A);
        check("t5_idle", busy8, 1'b0);

        // 6: odd bit period, floor mid-point
        send(1'b1, 7'h01, 1'b1);
        t5 = -1;
        for (int k = 0; k < 20 && t5 < 0; k++) begin
            @(negedge clk);
            if (code_valid5) t5 = cyc;
        end
        align();
        check("t6_latency", t5 - last_stop, SYNC + CPB5 / 2 + 1);
        check("t6_code_out", code_out5, 7'h01);
        check("t6_code_en", code_en5, 1'b1);
        check("t6_no_err", n_err5, 0);

        idle(5);
        check("model_drained", evq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_rx_deframer.md
Name: hamming_rx_deframer

Overview:
Serial receive front end directly upstream of the team's 7-bit Hamming(7,4) decoder. It samples an asynchronous, UART-style line carrying one 7-bit codeword per frame and reassembles the codeword. It presents the parallel word plus a decoder-enable qualifier, so the decoder only sees complete, well-framed codewords. Framing errors are flagged and never forwarded.

Parameters:
CLKS_PER_BIT, 16, clk cycles per line bit; legal range 4..1024; counter width = clog2(CLKS_PER_BIT).
SYNC_STAGES, 2, flops in the rx_in synchroniser; legal range 2..3.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx_in  input  1  serial line; idles high; asynchronous to clk
code_out  output  7  last good codeword, bit order matching the decoder input (code_out[0] is the first bit received)
code_valid  output  1  one-cycle pulse when code_out updates
code_en  output  1  high while code_out holds a good frame; drives the decoder enable
frame_err  output  1  one-cycle pulse on a bad stop bit
busy  output  1  high in any state except IDLE

Behaviour:
- Reset: one clock; asynchronous, active-low reset rst_n.
  - Asserting rst_n=0 forces: state IDLE, all counters 0, synchroniser flops 1, code_out=0, code_valid=0, code_en=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame silently; no pulses are emitted.
- Frame format: 1 start bit (0), 7 data bits (cw[0] first, cw[6] last), 1 stop bit (1). 9 bit-times total.
- Codeword layout, fixed by the downstream decoder:
  - Data bits: cw[6]=d3, cw[5]=d2, cw[4]=d1, cw[2]=d0.
  - Parity bits: cw[3]=d3^d2^d1, cw[1]=d3^d2^d0, cw[0]=d3^d1^d0.
  - This block does not check parity; it forwards the codeword unchanged.
- rx_in passes through SYNC_STAGES flops. All logic uses the synchronised bit rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rxs==0, go to START with baud counter cleared.
  - START: count to CLKS_PER_BIT/2-1 (mid-bit).
    - If rxs==1 there: glitch; return to IDLE with no flags.
    - Else clear the counter and go to DATA with bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift[idx] and increment idx.
    - After idx 6 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs==1: next cycle code_out<=shift, code_valid=1 for one cycle, code_en<=1.
    - rxs==0: next cycle frame_err=1 for one cycle, code_en<=0, code_out holds its previous value.
    - Either way, return to IDLE in the same cycle as the pulse.
- Exiting STOP requires no wait for the line to go high. A following start edge is accepted from IDLE on the next cycle; back-to-back frames are supported.
- Latency: code_valid rises 2 cycles after the mid-stop-bit sample. Counting from the rx_in stop-bit edge, that is SYNC_STAGES + CLKS_PER_BIT/2 + 1 cycles.
- code_en stays high across later good frames. It drops only on a frame error or reset.
- Odd CLKS_PER_BIT: the mid-point uses integer division (floor).
- No backpressure: the consumer must accept code_out on the code_valid cycle. code_out is stable until the next good frame.

Decomposition:
- Shared package: CW_W=7, DATA_W=4, FSM state enum, codeword bit-index constants (D3_POS=6, D2_POS=5, D1_POS=4, P0_POS=3, D0_POS=2, P1_POS=1, P2_POS=0). The decoder imports the same constants.
- One natural sub-module: bit_sync (SYNC_STAGES-deep synchroniser, reset value 1). The baud counter and FSM stay in this module.

Test Plan:
All scenarios use CLKS_PER_BIT=8, SYNC_STAGES=2.
1. Reset during DATA mid-frame, then release -> all outputs 0. A clean frame 0x55 sent afterwards is received correctly.
2. Nibble 1011, codeword 7'h55, good stop bit -> exactly one code_valid pulse, code_out=7'h55, code_en=1, frame_err never asserts. Pulse timing matches the latency formula.
3. Two back-to-back frames, 7'h55 then 7'h2A, with no idle gap -> two code_valid pulses 72 cycles apart, code_out=7'h2A after the second pulse.
4. Frame 7'h7F with stop bit 0 -> frame_err pulses once, code_valid stays 0, code_out keeps its prior value, code_en=0.
5. 3-cycle low glitch on an idle line -> returns to IDLE. busy high ≤6 cycles, no pulses, code_out unchanged.
6. CLKS_PER_BIT=5 (odd), frame 7'h01 -> samples taken at floor mid-point (2 cycles in), code_out=7'h01.
